// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, receiver state encoding and frame width.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [15:0] BPS_9600   = 16'd5207;
    localparam logic [15:0] BPS_19200  = 16'd2603;
    localparam logic [15:0] BPS_38400  = 16'd1301;
    localparam logic [15:0] BPS_57600  = 16'd867;
    localparam logic [15:0] BPS_115200 = 16'd433;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_baud_sel.sv
// baud_set to divisor lookup; the transmitter uses the same table so both ends agree.
module uart_baud_sel
    import uart_pkg::*;
(
    input  logic [2:0]  baud_set,
    output logic [15:0] bps_dr
);

    always_comb begin
        case (baud_set)
            3'd0:    bps_dr = BPS_9600;
            3'd1:    bps_dr = BPS_19200;
            3'd2:    bps_dr = BPS_38400;
            3'd3:    bps_dr = BPS_57600;
            3'd4:    bps_dr = BPS_115200;
            default: bps_dr = BPS_9600;
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and stop-bit framing check.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (decision one clock later).
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_set,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s, rxd_d1, fall;
    logic [15:0]            bps_sel, bps_q, bps_nxt, target;
    logic [15:0]            cnt_q, cnt_nxt;
    logic [2:0]             idx_q, idx_nxt;
    logic [DATA_BITS-1:0]   shift_q, shift_nxt, data_q, data_nxt;
    logic                   done_q, done_nxt, ferr_q, ferr_nxt;
    logic                   hit, decide, smp;
    rx_state_t              state_q, state_nxt;

    uart_baud_sel u_baud_sel (
        .baud_set (baud_set),
        .bps_dr   (bps_sel)
    );

    assign rxd_s = sync_q[SYNC_STAGES-1];
    assign fall  = rxd_d1 & ~rxd_s;

    // the counter wraps at the sample point in every mode; only the decision may lag
    assign target = (state_q == START) ? (bps_q >> 1) : bps_q;
    assign hit    = (state_q != IDLE) && (cnt_q == target);

`ifdef UART_RX_MAJORITY_EN
    logic rxd_d2, hit_q;
    assign decide = hit_q;
    assign smp    = (rxd_s & rxd_d1) | (rxd_s & rxd_d2) | (rxd_d1 & rxd_d2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_d2 <= 1'b1;
            hit_q  <= 1'b0;
        end else begin
            rxd_d2 <= rxd_d1;
            hit_q  <= hit;
        end
    end
`else
    assign decide = hit;
    assign smp    = rxd_s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '1;
            rxd_d1  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            bps_q   <= BPS_9600;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_d1  <= rxd_s;
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            shift_q <= shift_nxt;
            bps_q   <= bps_nxt;
            data_q  <= data_nxt;
            done_q  <= done_nxt;
            ferr_q  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        shift_nxt = shift_q;
        bps_nxt   = bps_q;
        data_nxt  = data_q;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;

        if (state_q != IDLE)
            cnt_nxt = hit ? 16'd0 : cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                cnt_nxt = '0;
                if (fall) begin
                    state_nxt = START;
                    bps_nxt   = bps_sel;
                end
            end
            START: begin
                if (decide) begin
                    if (smp) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_nxt = {smp, shift_q[DATA_BITS-1:1]};
                    idx_nxt   = idx_q + 3'd1;
                    if (idx_q == 3'(DATA_BITS - 1))
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (smp) begin
                        data_nxt = shift_q;
                        done_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged frames, scoreboard of expected rx_done/frame_err events.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] baud_set = 3'd4;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, rx_busy;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_set  (baud_set),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #10 clk = ~clk;

`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_115200 = 4127;
`else
    localparam int LAT_115200 = 4126;
`endif

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   event_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic err, input logic [7:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

    function automatic int bps_of(input int b);
        case (b)
            0: return 5207;
            1: return 2603;
            2: return 1301;
            3: return 867;
            4: return 433;
            default: return 5207;
        endcase
    endfunction

    // Called at a negedge; leaves the line at the stop level at a negedge.
    task automatic send_byte(input logic [7:0] d, input int bps, input logic stop, input logic glitch);
        int mid;
        mid = bps >> 1;
        rxd = 1'b0;
        repeat (bps + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (glitch) begin
                repeat (mid + 1) @(negedge clk);
                rxd = ~d[i];
                @(negedge clk);
                rxd = d[i];
                repeat (bps - mid - 1) @(negedge clk);
            end else begin
                repeat (bps + 1) @(negedge clk);
            end
        end
        rxd = stop;
        repeat (bps + 1) @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && (rx_done || frame_err)) begin
            event_cyc = cyc;
            check("done_ferr_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_event", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_is_ferr", {31'd0, frame_err}, {31'd0, e.err});
                check("event_rx_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
    end

    initial begin
        int t0;

        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // single byte at 115200 with latency measurement
        baud_set = 3'd4;
        sb.push_back(mk(1'b0, 8'hA5));
        t0 = cyc;
        send_byte(8'hA5, bps_of(4), 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("a5_pending", sb.size(), 32'd0);
        check("a5_latency", event_cyc - t0, LAT_115200);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);

        // back-to-back frames at 57600
        baud_set = 3'd3;
        repeat (20) @(negedge clk);
        sb.push_back(mk(1'b0, 8'h00));
        sb.push_back(mk(1'b0, 8'hFF));
        sb.push_back(mk(1'b0, 8'h3C));
        send_byte(8'h00, bps_of(3), 1'b1, 1'b0);
        send_byte(8'hFF, bps_of(3), 1'b1, 1'b0);
        send_byte(8'h3C, bps_of(3), 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("b2b_pending", sb.size(), 32'd0);
        check("b2b_rx_data", {24'd0, rx_data}, 32'h3C);

        // framing error keeps the previous byte, then a good frame
        baud_set = 3'd2;
        repeat (20) @(negedge clk);
        sb.push_back(mk(1'b1, 8'h3C));
        send_byte(8'h5A, bps_of(2), 1'b0, 1'b0);
        check("ferr_pending", sb.size(), 32'd0);
        check("ferr_rx_data", {24'd0, rx_data}, 32'h3C);
        rxd = 1'b1;
        repeat (bps_of(2) + 1) @(negedge clk);
        sb.push_back(mk(1'b0, 8'h12));
        send_byte(8'h12, bps_of(2), 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("after_ferr_pending", sb.size(), 32'd0);
        check("after_ferr_rx_data", {24'd0, rx_data}, 32'h12);

        // baud_set change during bit 3 does not disturb the frame in flight
        baud_set = 3'd4;
        repeat (20) @(negedge clk);
        sb.push_back(mk(1'b0, 8'hC3));
        fork
            send_byte(8'hC3, bps_of(4), 1'b1, 1'b0);
            begin
                repeat (434 * 4 + 200) @(negedge clk);
                baud_set = 3'd0;
            end
        join
        repeat (20) @(negedge clk);
        check("baudchg_pending", sb.size(), 32'd0);
        check("baudchg_rx_data", {24'd0, rx_data}, 32'hC3);

        // glitch at 9600: start bit shorter than half a bit is rejected
        rxd = 1'b0;
        repeat (1000) @(negedge clk);
        rxd = 1'b1;
        repeat (1550) @(negedge clk);
        check("glitch_busy_before_mid", {31'd0, rx_busy}, 32'd1);
        repeat (100) @(negedge clk);
        check("glitch_busy_after_mid", {31'd0, rx_busy}, 32'd0);
        repeat (1850) @(negedge clk);
        check("glitch_busy_idle", {31'd0, rx_busy}, 32'd0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'hC3);

        // reset in the middle of DATA
        baud_set = 3'd4;
        repeat (20) @(negedge clk);
        rxd = 1'b0;
        repeat (434 * 3) @(negedge clk);
        check("rst_busy_before", {31'd0, rx_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (500) @(negedge clk);
        sb.push_back(mk(1'b0, 8'h81));
        send_byte(8'h81, bps_of(4), 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("post_rst_pending", sb.size(), 32'd0);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_MAJORITY_EN
        // single-clock inversions at each data sample point are outvoted
        repeat (20) @(negedge clk);
        sb.push_back(mk(1'b0, 8'h96));
        send_byte(8'h96, bps_of(4), 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("maj_pending", sb.size(), 32'd0);
        check("maj_rx_data", {24'd0, rx_data}, 32'h96);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
